xorshift32_arbiter: RTL and testbench

Controller that owns one `xorshift32` generator and shares its output among `NUM_REQ` requesters, one 32-bit number per grant, round-robin. It also sequences generator seeding:
- initial seeding out of reset;
- run-time reseed requests;
- zero-seed substitution;
- a warm-up discard window.

It sits between the stochastic-compute consumers and the raw RNG, so no consumer ever drives `re_seed` directly.

---
 rtl/xorshift32_arbiter.sv | 178 +++++++++++++++++
 tb/tb_xorshift32_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xorshift32_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xorshift32_arbiter (with helper module xorshift32)              |
// | Purpose  : Owns one xorshift32 generator and hands out one 32-bit word per |
// |            grant to NUM_REQ requesters in round-robin order. It also      |
// |            sequences seeding: reset seed, run-time reseed, zero-seed      |
// |            substitution and a warm-up discard window after every load.    |
// | Ports    : clk, rst (async, active high)                                  |
// |            req[NUM_REQ]  in  : request levels, held until granted         |
// |            gnt[NUM_REQ]  out : registered one-hot grant, one cycle        |
// |            rnd_out[32]   out : registered word, valid while gnt != 0      |
// |            seed_req      in  : reseed request level, held until seed_ack  |
// |            seed_in[32]   in  : requested seed, sampled on acceptance      |
// |            seed_ack      out : registered one-cycle acceptance pulse      |
// |            busy          out : high while seeding or warming up           |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+

// Raw generator: loads seed while re_seed is high, otherwise advances one
// xorshift32 step (13, 17, 5) per clock. rnd is the current state.
module xorshift32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        re_seed,
    input  logic [31:0] seed,
    output logic [31:0] rnd
);

    logic [31:0] r_state;
    logic [31:0] w_x1;
    logic [31:0] w_x2;
    logic [31:0] w_x3;

    always_comb begin
        w_x1 = r_state ^ (r_state << 13);
        w_x2 = w_x1 ^ (w_x1 >> 17);
        w_x3 = w_x2 ^ (w_x2 << 5);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 32'd0;
        end else if (re_seed) begin
            r_state <= seed;
        end else begin
            r_state <= w_x3;
        end
    end

    assign rnd = r_state;

endmodule

module xorshift32_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter int          WARMUP       = 8,
    parameter logic [31:0] DEFAULT_SEED = 32'h2545F491
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_out,
    input  logic               seed_req,
    input  logic [31:0]        seed_in,
    output logic               seed_ack,
    output logic               busy
);

    localparam int         c_ptr_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] c_warmup   = 8'(WARMUP);
    localparam logic [1:0] c_st_seed  = 2'd0;
    localparam logic [1:0] c_st_warm  = 2'd1;
    localparam logic [1:0] c_st_serve = 2'd2;

    logic [1:0]         r_state;
    logic [31:0]        r_seed;
    logic [7:0]         r_warm_cnt;
    logic [c_ptr_w-1:0] r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [31:0]        r_rnd;
    logic               r_seed_ack;

    logic               w_rst_n;
    logic               w_re_seed;
    logic [31:0]        w_s_cur;
    logic [31:0]        w_seed_next;
    logic               w_found;
    logic [c_ptr_w-1:0] w_idx;
    logic [c_ptr_w-1:0] w_winner;
    logic [NUM_REQ-1:0] w_onehot;

    assign w_rst_n   = ~rst;
    assign w_re_seed = (r_state == c_st_seed);

    xorshift32 u_gen (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .re_seed (w_re_seed),
        .seed    (r_seed),
        .rnd     (w_s_cur)
    );

    // A zero seed would lock xorshift at zero forever, so it is replaced.
    assign w_seed_next = (seed_in == 32'd0) ? DEFAULT_SEED : seed_in;

    // Round-robin search: first asserted request starting one past the
    // last winner, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = c_ptr_w'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_onehot = NUM_REQ'(1) << w_winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_seed;
            r_seed     <= DEFAULT_SEED;
            r_warm_cnt <= 8'd0;
            r_ptr      <= c_ptr_w'(NUM_REQ - 1);
            r_gnt      <= '0;
            r_rnd      <= 32'd0;
            r_seed_ack <= 1'b0;
        end else begin
            // Grant and ack are single-cycle pulses unless set below.
            r_gnt      <= '0;
            r_seed_ack <= 1'b0;
            case (r_state)
                c_st_seed: begin
                    if (WARMUP > 0) begin
                        r_state    <= c_st_warm;
                        r_warm_cnt <= c_warmup;
                    end else begin
                        r_state <= c_st_serve;
                    end
                end
                c_st_warm: begin
                    r_warm_cnt <= r_warm_cnt - 8'd1;
                    if (r_warm_cnt == 8'd1) begin
                        r_state <= c_st_serve;
                    end
                end
                c_st_serve: begin
                    // Reseed wins over any pending grant.
                    if (seed_req) begin
                        r_seed     <= w_seed_next;
                        r_seed_ack <= 1'b1;
                        r_state    <= c_st_seed;
                    end else if (w_found) begin
                        r_gnt <= w_onehot;
                        r_rnd <= w_s_cur;
                        r_ptr <= w_winner;
                    end
                end
                default: begin
                    r_state <= c_st_seed;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign rnd_out  = r_rnd;
    assign seed_ack = r_seed_ack;
    assign busy     = (r_state == c_st_seed) || (r_state == c_st_warm);

endmodule

`default_nettype wire

// File: tb/tb_xorshift32_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xorshift32_arbiter                                           |
// | Purpose  : Directed self-checking bench. dut0 has WARMUP=0, dut1 has       |
// |            WARMUP=2; both use DEFAULT_SEED=1 so the expected words are    |
// |            the hand-computed xorshift32 sequence from seed 1.             |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_xorshift32_arbiter;

    // xorshift32(13,17,5) sequence from seed 1, computed by hand.
    localparam logic [31:0] c_s0 = 32'h00000001;
    localparam logic [31:0] c_s1 = 32'h00042021;
    localparam logic [31:0] c_s2 = 32'h04080601;
    localparam logic [31:0] c_s3 = 32'h9DCCA8C5;

    logic        clk;
    logic        rst;
    logic [3:0]  req0, gnt0, req1, gnt1;
    logic [31:0] rnd0, rnd1, sin0, sin1;
    logic        sreq0, ack0, busy0, sreq1, ack1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    xorshift32_arbiter #(.NUM_REQ(4), .WARMUP(0), .DEFAULT_SEED(32'h1)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .gnt(gnt0), .rnd_out(rnd0),
        .seed_req(sreq0), .seed_in(sin0), .seed_ack(ack0), .busy(busy0)
    );

    xorshift32_arbiter #(.NUM_REQ(4), .WARMUP(2), .DEFAULT_SEED(32'h1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .rnd_out(rnd1),
        .seed_req(sreq1), .seed_in(sin1), .seed_ack(ack1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset state, then reset seeding with WARMUP=0 and req[0] held.
    task automatic test_reset;
        int nbusy;
        logic [31:0] exp_rnd [3];
        exp_rnd = '{c_s0, c_s1, c_s2};
        rst = 1'b1; req0 = '0; req1 = '0; sreq0 = 1'b0; sreq1 = 1'b0; sin0 = '0; sin1 = '0;
        @(negedge clk);
        n_checks++; if (gnt0 !== 4'b0000) begin n_errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt0); end
        n_checks++; if (rnd0 !== 32'd0) begin n_errors++; $display("FAIL rst_rnd: got %h expected 0", rnd0); end
        n_checks++; if (ack0 !== 1'b0) begin n_errors++; $display("FAIL rst_ack: got %b expected 0", ack0); end
        n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL rst_busy: got %b expected 1", busy0); end
        req0 = 4'b0001;
        rst  = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 10 && busy0 === 1'b1; k++) begin nbusy++; @(negedge clk); end
        n_checks++; if (nbusy != 1) begin n_errors++; $display("FAIL seed_busy_len: got %0d expected 1", nbusy); end
        n_checks++; if (gnt0 !== 4'b0000) begin n_errors++; $display("FAIL seed_first_serve_gnt: got %b expected 0000", gnt0); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (gnt0 !== 4'b0001) begin n_errors++; $display("FAIL seed_gnt[%0d]: got %b expected 0001", k, gnt0); end
            n_checks++; if (rnd0 !== exp_rnd[k]) begin n_errors++; $display("FAIL seed_rnd[%0d]: got %h expected %h", k, rnd0, exp_rnd[k]); end
        end
    endtask

    // WARMUP=2: busy for SEED + 2 WARM cycles, first word is seed advanced twice.
    task automatic test_warmup;
        int nbusy;
        rst = 1'b1;
        @(negedge clk);
        req0 = '0; req1 = 4'b0001;
        rst = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 10 && busy1 === 1'b1; k++) begin nbusy++; @(negedge clk); end
        n_checks++; if (nbusy != 3) begin n_errors++; $display("FAIL warm_busy_len: got %0d expected 3", nbusy); end
        n_checks++; if (gnt1 !== 4'b0000) begin n_errors++; $display("FAIL warm_serve_gnt: got %b expected 0000", gnt1); end
        @(negedge clk);
        n_checks++; if (gnt1 !== 4'b0001) begin n_errors++; $display("FAIL warm_gnt: got %b expected 0001", gnt1); end
        n_checks++; if (rnd1 !== c_s2) begin n_errors++; $display("FAIL warm_rnd: got %h expected %h", rnd1, c_s2); end
    endtask

    // All four requesting, then req[2] dropped right after the 0010 grant.
    task automatic test_round_robin;
        logic [3:0]  exp_gnt [6];
        logic [31:0] exp_rnd [3];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_rnd = '{c_s0, c_s1, c_s2};
        rst = 1'b1;
        @(negedge clk);
        req0 = 4'b1111;
        rst  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++; if (gnt0 !== exp_gnt[k]) begin n_errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt0, exp_gnt[k]); end
            if (k < 3) begin
                n_checks++; if (rnd0 !== exp_rnd[k]) begin n_errors++; $display("FAIL rr_rnd[%0d]: got %h expected %h", k, rnd0, exp_rnd[k]); end
            end
        end
        req0 = 4'b1011;
        @(negedge clk);
        n_checks++; if (gnt0 !== 4'b1000) begin n_errors++; $display("FAIL rr_skip_gnt: got %b expected 1000", gnt0); end
        @(negedge clk);
        n_checks++; if (gnt0 !== 4'b0001) begin n_errors++; $display("FAIL rr_wrap_gnt: got %b expected 0001", gnt0); end
    endtask

    // Idle cycles discard generator values; sole requester granted every cycle.
    task automatic test_idle_sole;
        rst = 1'b1;
        @(negedge clk);
        req0 = 4'b0000;
        rst  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (gnt0 !== 4'b0000) begin n_errors++; $display("FAIL idle_gnt[%0d]: got %b expected 0000", k, gnt0); end
            n_checks++; if (rnd0 !== 32'd0) begin n_errors++; $display("FAIL idle_rnd[%0d]: got %h expected 0", k, rnd0); end
        end
        req0 = 4'b0100;
        @(negedge clk);
        n_checks++; if (gnt0 !== 4'b0100) begin n_errors++; $display("FAIL sole_gnt0: got %b expected 0100", gnt0); end
        n_checks++; if (rnd0 !== c_s2) begin n_errors++; $display("FAIL sole_rnd0: got %h expected %h", rnd0, c_s2); end
        @(negedge clk);
        n_checks++; if (gnt0 !== 4'b0100) begin n_errors++; $display("FAIL sole_gnt1: got %b expected 0100", gnt0); end
        n_checks++; if (rnd0 !== c_s3) begin n_errors++; $display("FAIL sole_rnd1: got %h expected %h", rnd0, c_s3); end
        req0 = 4'b0000;
        @(negedge clk);
        n_checks++; if (gnt0 !== 4'b0000) begin n_errors++; $display("FAIL hold_gnt: got %b expected 0000", gnt0); end
        n_checks++; if (rnd0 !== c_s3) begin n_errors++; $display("FAIL hold_rnd: got %h expected %h", rnd0, c_s3); end
    endtask

    // Reseed on dut0: zero seed -> DEFAULT_SEED, then an explicit nonzero seed.
    task automatic test_reseed;
        logic [31:0] seeds [2];
        logic [31:0] exp_a [2];
        logic [31:0] exp_b [2];
        seeds = '{32'd0, c_s2};
        exp_a = '{c_s0, c_s2};
        exp_b = '{c_s1, c_s3};
        for (int r = 0; r < 2; r++) begin
            req0 = 4'b0001; sreq0 = 1'b1; sin0 = seeds[r];
            @(negedge clk);
            n_checks++; if (ack0 !== 1'b1) begin n_errors++; $display("FAIL reseed%0d_ack: got %b expected 1", r, ack0); end
            n_checks++; if (gnt0 !== 4'b0000) begin n_errors++; $display("FAIL reseed%0d_nogrant: got %b expected 0000", r, gnt0); end
            n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL reseed%0d_busy: got %b expected 1", r, busy0); end
            sreq0 = 1'b0; sin0 = 32'hDEADBEEF;
            @(negedge clk);
            n_checks++; if (ack0 !== 1'b0) begin n_errors++; $display("FAIL reseed%0d_ack_pulse: got %b expected 0", r, ack0); end
            n_checks++; if (gnt0 !== 4'b0000) begin n_errors++; $display("FAIL reseed%0d_seed_gnt: got %b expected 0000", r, gnt0); end
            @(negedge clk);
            n_checks++; if (gnt0 !== 4'b0001) begin n_errors++; $display("FAIL reseed%0d_gnt: got %b expected 0001", r, gnt0); end
            n_checks++; if (rnd0 !== exp_a[r]) begin n_errors++; $display("FAIL reseed%0d_rnd_a: got %h expected %h", r, rnd0, exp_a[r]); end
            @(negedge clk);
            n_checks++; if (rnd0 !== exp_b[r]) begin n_errors++; $display("FAIL reseed%0d_rnd_b: got %h expected %h", r, rnd0, exp_b[r]); end
        end
    endtask

    // dut1: reseed collides with a request; then seed_req raised during WARM.
    task automatic test_collision;
        int idle;
        req1 = 4'b0001; sreq1 = 1'b1; sin1 = 32'd0;
        @(negedge clk);
        n_checks++; if (ack1 !== 1'b1) begin n_errors++; $display("FAIL coll_ack: got %b expected 1", ack1); end
        n_checks++; if (gnt1 !== 4'b0000) begin n_errors++; $display("FAIL coll_gnt: got %b expected 0000", gnt1); end
        sreq1 = 1'b0;
        idle = 0;
        @(negedge clk);
        while (gnt1 === 4'b0000 && idle < 10) begin idle++; @(negedge clk); end
        // SEED cycle + WARMUP cycles of WARM, then the SERVE decision.
        n_checks++; if (idle != 3) begin n_errors++; $display("FAIL coll_idle: got %0d expected 3", idle); end
        n_checks++; if (gnt1 !== 4'b0001) begin n_errors++; $display("FAIL coll_late_gnt: got %b expected 0001", gnt1); end
        n_checks++; if (rnd1 !== c_s2) begin n_errors++; $display("FAIL coll_late_rnd: got %h expected %h", rnd1, c_s2); end

        sreq1 = 1'b1; sin1 = 32'd0;
        @(negedge clk);
        sreq1 = 1'b0;
        @(negedge clk);
        n_checks++; if (busy1 !== 1'b1) begin n_errors++; $display("FAIL warmreq_busy: got %b expected 1", busy1); end
        sreq1 = 1'b1; sin1 = 32'h1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (ack1 !== 1'b0) begin n_errors++; $display("FAIL warmreq_noack[%0d]: got %b expected 0", k, ack1); end
        end
        @(negedge clk);
        n_checks++; if (ack1 !== 1'b1) begin n_errors++; $display("FAIL warmreq_ack: got %b expected 1", ack1); end
        n_checks++; if (gnt1 !== 4'b0000) begin n_errors++; $display("FAIL warmreq_gnt: got %b expected 0000", gnt1); end
        sreq1 = 1'b0;
        idle = 0;
        @(negedge clk);
        while (gnt1 === 4'b0000 && idle < 10) begin idle++; @(negedge clk); end
        n_checks++; if (idle != 3) begin n_errors++; $display("FAIL warmreq_idle: got %0d expected 3", idle); end
        n_checks++; if (rnd1 !== c_s2) begin n_errors++; $display("FAIL warmreq_rnd: got %h expected %h", rnd1, c_s2); end
    endtask

    // Reset pulse with dut0 granting and dut1 in WARM; both restart cleanly.
    task automatic test_reset_mid;
        logic        eb0 [5];
        logic        eb1 [5];
        logic [3:0]  eg0 [5];
        logic [3:0]  eg1 [5];
        logic [31:0] er0 [5];
        logic [31:0] er1 [5];
        eb0 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        eg0 = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        er0 = '{32'd0, 32'd0, c_s0, c_s1, c_s2};
        eb1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        eg1 = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        er1 = '{32'd0, 32'd0, 32'd0, 32'd0, c_s2};
        req0 = 4'b0001; req1 = 4'b0001; sreq1 = 1'b1; sin1 = 32'd0;
        @(negedge clk);
        sreq1 = 1'b0;
        @(negedge clk);
        n_checks++; if (gnt0 !== 4'b0001) begin n_errors++; $display("FAIL mid_pre_gnt0: got %b expected 0001", gnt0); end
        n_checks++; if (busy1 !== 1'b1) begin n_errors++; $display("FAIL mid_pre_busy1: got %b expected 1", busy1); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (gnt0 !== 4'b0000 || rnd0 !== 32'd0 || ack0 !== 1'b0 || busy0 !== 1'b1) begin
            n_errors++; $display("FAIL mid_rst_dut0: got gnt=%b rnd=%h ack=%b busy=%b expected 0000 0 0 1", gnt0, rnd0, ack0, busy0);
        end
        n_checks++; if (gnt1 !== 4'b0000 || rnd1 !== 32'd0 || ack1 !== 1'b0 || busy1 !== 1'b1) begin
            n_errors++; $display("FAIL mid_rst_dut1: got gnt=%b rnd=%h ack=%b busy=%b expected 0000 0 0 1", gnt1, rnd1, ack1, busy1);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++; if (busy0 !== eb0[k] || gnt0 !== eg0[k] || rnd0 !== er0[k]) begin
                n_errors++; $display("FAIL mid_seq0[%0d]: got busy=%b gnt=%b rnd=%h expected %b %b %h", k, busy0, gnt0, rnd0, eb0[k], eg0[k], er0[k]);
            end
            n_checks++; if (busy1 !== eb1[k] || gnt1 !== eg1[k] || rnd1 !== er1[k]) begin
                n_errors++; $display("FAIL mid_seq1[%0d]: got busy=%b gnt=%b rnd=%h expected %b %b %h", k, busy1, gnt1, rnd1, eb1[k], eg1[k], er1[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = '0; req1 = '0; sreq0 = 1'b0; sreq1 = 1'b0; sin0 = '0; sin1 = '0;
        test_reset;
        test_warmup;
        test_round_robin;
        test_idle_sole;
        test_reseed;
        test_collision;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
